// File: rtl/rle_sched_pkg.sv
// rle_sched_pkg: shared FSM states, symbol width and encoder output record for the RLE scheduler
package rle_sched_pkg;
  localparam int SYM_W = 7;
  typedef enum logic [2:0] {IDLE, HDR, STREAM, FLUSH, DRAIN} state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } enc_out_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first requesting channel searching upward from last_grant+1, wrapping modulo NUM_CH
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int CHAN_W = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHAN_W-1:0] last_grant,
  output logic [CHAN_W-1:0] winner,
  output logic              any_req
);
  logic [CHAN_W-1:0] k;
  // walk offsets from farthest to nearest so the nearest request overwrites the rest
  always_comb begin
    winner = '0;
    k = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      k = CHAN_W'((int'(last_grant) + i) % NUM_CH);
      winner = req[k] ? k : winner;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/rle_channel_scheduler.sv
// rle_channel_scheduler: round-robin bursts from NUM_CH sources into one RLE encoder, with headers and flushes.
// Optional RLE_SCHED_TIMEOUT_EN ends a burst after TIMEOUT consecutive stalled cycles.
module rle_channel_scheduler
  import rle_sched_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int BURST_MAX = 255,
  parameter int CHAN_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_valid_i,
  input  logic [NUM_CH*SYM_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]       ch_last_i,
  output logic [NUM_CH-1:0]       ch_ready_o,
  output logic [SYM_W-1:0]        enc_data_o,
  output logic                    enc_valid_o,
  output logic                    enc_flush_o,
  input  logic                    enc_idle_i,
  output logic                    hdr_valid_o,
  output logic [CHAN_W-1:0]       hdr_chan_o,
  output logic                    busy_o
);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  state_t            state, next;
  logic [CHAN_W-1:0] winner, last_grant, pick;
  logic [CNT_W-1:0]  beat_cnt;
  logic              any_req, beat, done, timeout;
  logic [SYM_W-1:0]  sym;
  rr_pick #(.NUM_CH(NUM_CH), .CHAN_W(CHAN_W)) u_pick (
    .req(ch_valid_i),
    .last_grant(last_grant),
    .winner(pick),
    .any_req(any_req)
  );
  assign sym  = ch_data_i[winner*SYM_W +: SYM_W];
  assign beat = (state == STREAM) && ch_valid_i[winner];
`ifdef RLE_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall;
  assign timeout = (state == STREAM) && !ch_valid_i[winner] && (stall == STALL_W'(TIMEOUT - 1));
  always_ff @(posedge clock)
    stall <= (reset || state != STREAM || beat) ? '0 : stall + 1'b1;
`else
  logic unused_timeout;
  assign timeout = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif
  // the ending beat is still forwarded; last and BURST_MAX together give one end
  assign done = (beat && (ch_last_i[winner] || beat_cnt == CNT_W'(BURST_MAX - 1))) || timeout;
  always_comb
    next = (state == IDLE)   ? (any_req ? HDR : IDLE) :
           (state == HDR)    ? STREAM :
           (state == STREAM) ? (done ? FLUSH : STREAM) :
           (state == FLUSH)  ? DRAIN :
           (enc_idle_i ? IDLE : DRAIN);
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      winner     <= '0;
      last_grant <= CHAN_W'(NUM_CH - 1);
      beat_cnt   <= '0;
    end else begin
      state <= next;
      if (state == IDLE && any_req) winner <= pick;
      if (beat) beat_cnt <= beat_cnt + 1'b1;
      if (state == FLUSH) begin
        last_grant <= winner;
        beat_cnt   <= '0;
      end
    end
  end
  assign ch_ready_o  = (state == STREAM) ? NUM_CH'(1) << winner : '0;
  assign enc_valid_o = beat;
  assign enc_data_o  = beat ? sym : '0;
  assign enc_flush_o = state == FLUSH;
  assign hdr_valid_o = state == HDR;
  assign hdr_chan_o  = hdr_valid_o ? winner : '0;
  assign busy_o      = state != IDLE;
endmodule

// File: tb/tb_rle_channel_scheduler.sv
// tb_rle_channel_scheduler: random sources checked against a queue-level burst model via a scoreboard
module tb_rle_channel_scheduler;
  import rle_sched_pkg::*;
  localparam int NUM_CH = 4;
  localparam int BURST_MAX = 255;
  localparam int CHAN_W = 2;
  logic clock = 1'b0;
  logic reset;
  logic [NUM_CH-1:0] ch_valid, ch_last, ch_ready;
  logic [NUM_CH*SYM_W-1:0] ch_data;
  logic [SYM_W-1:0] enc_data;
  logic enc_valid, enc_flush, enc_idle, hdr_valid, busy;
  logic [CHAN_W-1:0] hdr_chan;
  int errors = 0;
  int checks = 0;
  int mlast;
  bit mon_en = 0;
  typedef struct {
    int kind;
    int chan;
    int data;
  } ev_t;
  ev_t exp_q[$];
  int src_q [NUM_CH][$];
  always #5 clock = ~clock;
  rle_channel_scheduler #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX), .CHAN_W(CHAN_W), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_last_i(ch_last), .ch_ready_o(ch_ready),
    .enc_data_o(enc_data), .enc_valid_o(enc_valid), .enc_flush_o(enc_flush), .enc_idle_i(enc_idle),
    .hdr_valid_o(hdr_valid), .hdr_chan_o(hdr_chan), .busy_o(busy)
  );
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic pop_cmp(input int k, input int ch, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("extra_event", k, -1);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", k, e.kind);
    chk("event_chan", ch, e.chan);
    chk("event_data", d, e.data);
  endtask
  // burst sequence from the rules alone: round-robin over channels with pending data
  task automatic model();
    int q [NUM_CH][$];
    for (int c = 0; c < NUM_CH; c++) q[c] = src_q[c];
    while (1) begin
      int w;
      w = -1;
      for (int o = NUM_CH; o >= 1; o--) if (q[(mlast + o) % NUM_CH].size() != 0) w = (mlast + o) % NUM_CH;
      if (w < 0) break;
      exp_q.push_back('{0, w, 0});
      for (int n = 1; n <= BURST_MAX; n++) begin
        int v;
        v = q[w].pop_front();
        exp_q.push_back('{1, w, v % 128});
        if (v >= 128) break;
      end
      exp_q.push_back('{2, 0, 0});
      mlast = w;
    end
  endtask
  bit dr = 0;
  int since = 0;
  bit pidle = 0;
  always @(negedge clock) begin
    int g;
    if (mon_en) begin
      g = -1;
      for (int c = 0; c < NUM_CH; c++) if (ch_ready[c]) g = c;
      chk("ready_onehot", int'($countones(ch_ready) <= 1), 1);
      if (!enc_valid) chk("idle_data_zero", int'(enc_data), 0);
      if (hdr_valid) pop_cmp(0, int'(hdr_chan), 0);
      if (enc_valid) pop_cmp(1, g, int'(enc_data));
      if (enc_flush) begin
        pop_cmp(2, 0, 0);
        chk("flush_ready_low", int'(ch_ready), 0);
      end
      if (dr) begin
        since++;
        if (since == 1) chk("drain_entry", int'(busy), 1);
        else begin
          chk("drain_exit", int'(!busy), int'(pidle));
          if (!busy) dr = 0;
        end
      end
      if (enc_flush) begin
        dr = 1;
        since = 0;
      end
      pidle = enc_idle;
    end else dr = 0;
  end
  task automatic step();
    @(negedge clock);
    for (int c = 0; c < NUM_CH; c++)
      if (ch_valid[c] && ch_ready[c] && src_q[c].size() != 0) void'(src_q[c].pop_front());
    @(posedge clock);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() != 0 && !(ch_ready[c] && $urandom_range(3) == 0)) begin
        int v;
        v = src_q[c][0];
        ch_valid[c] = 1'b1;
        ch_data[c*SYM_W +: SYM_W] = SYM_W'(v % 128);
        ch_last[c] = v >= 128;
      end else begin
        ch_valid[c] = 1'b0;
        ch_data[c*SYM_W +: SYM_W] = '0;
        ch_last[c] = 1'b0;
      end
    end
    enc_idle = $urandom_range(2) != 0;
  endtask
  task automatic pkt(input int c, input int len, input int d);
    for (int i = 1; i <= len; i++)
      src_q[c].push_back(((d >= 0) ? d : int'($urandom_range(127))) + ((i == len) ? 128 : 0));
  endtask
  task automatic run(input int budget);
    int cyc, left;
    cyc = 0;
    left = 0;
    model();
    mon_en = 1;
    while ((exp_q.size() != 0 || busy) && cyc < budget) begin
      step();
      cyc++;
    end
    chk("scenario_in_budget", int'(cyc < budget), 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    for (int c = 0; c < NUM_CH; c++) left += src_q[c].size();
    chk("sources_drained", left, 0);
  endtask
  initial begin
    int cyc;
    reset = 1'b1;
    ch_valid = '0;
    ch_data = '0;
    ch_last = '0;
    enc_idle = 1'b1;
    repeat (3) step();
    chk("rst_ready", int'(ch_ready), 0);
    chk("rst_enc_valid", int'(enc_valid), 0);
    chk("rst_enc_data", int'(enc_data), 0);
    chk("rst_flush", int'(enc_flush), 0);
    chk("rst_hdr_valid", int'(hdr_valid), 0);
    chk("rst_hdr_chan", int'(hdr_chan), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    mlast = NUM_CH - 1;
    pkt(2, 3, 'h37);
    run(200);
    for (int r = 0; r < 3; r++) for (int c = 0; c < NUM_CH; c++) pkt(c, 2, -1);
    run(1000);
    pkt(1, 300, 8);
    run(2000);
    pkt(3, 255, -1);
    pkt(3, 2, -1);
    run(2000);
    pkt(0, 4, -1);
    run(200);
    pkt(0, 3, -1);
    pkt(3, 3, -1);
    run(300);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int np;
        np = int'($urandom_range(3));
        for (int p = 0; p < np; p++)
          pkt(c, ($urandom_range(5) == 0) ? int'($urandom_range(400, 200)) : int'($urandom_range(12, 1)), -1);
      end
      run(20000);
    end
    mon_en = 0;
    pkt(2, 50, -1);
    cyc = 0;
    while (src_q[2].size() > 41 && cyc < 300) begin
      step();
      cyc++;
    end
    chk("reach_beat10", int'(cyc < 300), 1);
    chk("beat10_busy", int'(busy), 1);
    reset = 1'b1;
    src_q[2].delete();
    step();
    chk("midrst_ready", int'(ch_ready), 0);
    chk("midrst_enc_valid", int'(enc_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_flush", int'(enc_flush), 0);
    chk("midrst_hdr_valid", int'(hdr_valid), 0);
    reset = 1'b0;
    mlast = NUM_CH - 1;
    for (int c = NUM_CH - 1; c >= 0; c--) pkt(c, 5, -1);
    run(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
